fetch_ctrl: RTL

Instruction fetch controller that drives the program counter register and reads the instruction memory. Each cycle it decides whether the PC advances: sequential +PC_STEP after a completed fetch, or a redirect target from execute. It runs a req/ack handshake to instruction memory and holds one fetched instruction for decode under a valid/ready handshake.

---
 rtl/fetch_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences PC updates, drives a req/ack fetch to
// instruction memory and holds one fetched instruction for decode.
module fetch_ctrl #(
  parameter int BITSIZE     = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_STEP     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BITSIZE-1:0]     pc_in,
  output logic [BITSIZE-1:0]     pc_next,
  output logic                   pc_enable,
  output logic                   imem_req,
  output logic [BITSIZE-1:0]     imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [BITSIZE-1:0]     instr_pc,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [BITSIZE-1:0]     redirect_target,
  output logic                   fetch_fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  state_t             state;
  logic [BITSIZE-1:0] req_addr;
  logic               discard;
  logic               ack_take;

  assign imem_req  = (state == FETCH);
  assign imem_addr = req_addr;
  assign ack_take  = (state == FETCH) && imem_ack;

  // Redirect wins over the sequential step; a stale (discarded) ack never advances the PC.
  always_comb begin
    pc_enable = 1'b0;
    pc_next   = '0;
    if (!reset) begin
      if (redirect_valid) begin
        pc_enable = 1'b1;
        pc_next   = redirect_target;
      end else if (ack_take && !discard) begin
        pc_enable = 1'b1;
        pc_next   = req_addr + BITSIZE'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_addr    <= '0;
      discard     <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A redirect this cycle means pc_in is about to change; wait for it.
          if (!redirect_valid) begin
            if (pc_in[1:0] == 2'b00) begin
              req_addr <= pc_in;
              state    <= FETCH;
            end else begin
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end
          end
        end
        FETCH: begin
          if (imem_ack) begin
            discard <= 1'b0;
            if (redirect_valid || discard) begin
              state <= IDLE;
            end else begin
              instr_out   <= imem_rdata;
              instr_pc    <= req_addr;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (redirect_valid) begin
            // Address must stay stable until ack, so let it finish and drop the data.
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        FAULT: begin
          if (redirect_valid) begin
            fetch_fault <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
